// File: rtl/cond_pipe_ctrl.sv
// cond_pipe_ctrl: D->E control register, NZCV flag register and E-stage condition gating.
// Optional COND_STATS_EN adds executed/squashed instruction counters.
module cond_pipe_ctrl #(
    parameter int ALUCTRL_W = 2,
    parameter int NFGRP = 2
`ifdef COND_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StallE,
    input  logic                 FlushE,
    input  logic                 PCSrcD,
    input  logic                 RegWriteD,
    input  logic                 MemWriteD,
    input  logic                 MemtoRegD,
    input  logic                 BranchD,
    input  logic                 ALUSrcD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic [NFGRP-1:0]     FlagWriteD,
    input  logic [3:0]           CondD,
    input  logic [3:0]           ALUFlags,
    output logic                 MemtoRegE,
    output logic                 ALUSrcE,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ValidE,
    output logic                 CondExE,
    output logic                 PCSrcE,
    output logic                 RegWriteE,
    output logic                 MemWriteE,
    output logic                 BranchTakenE,
`ifdef COND_STATS_EN
    output logic [CNT_W-1:0]     ExecCnt,
    output logic [CNT_W-1:0]     SquashCnt,
`endif
    output logic [3:0]           Flags
);
    localparam int W = 10 + ALUCTRL_W + NFGRP;
    logic [W-1:0]     ctrl_d, ctrl_q;
    logic             valid_d, valid_q;
    logic [3:0]       flags_d, flags_q, fmask;
    logic             pcsrc_f, regwrite_f, memwrite_f, branch_f, gate, upd;
    logic [NFGRP-1:0] flagwrite_f;
    logic [3:0]       cond_f;
    logic             n, z, c, v;
    assign {pcsrc_f, regwrite_f, memwrite_f, MemtoRegE, branch_f, ALUSrcE, ALUControlE, flagwrite_f, cond_f} = ctrl_q;
    assign {n, z, c, v} = flags_q;
    // Each flag bit follows the flag-write group that covers it.
    for (genvar g = 0; g < 4; g++) begin : g_mask
        assign fmask[g] = flagwrite_f[g*NFGRP/4];
    end
    always_comb begin
        case (cond_f)
            4'h0: CondExE = z;
            4'h1: CondExE = ~z;
            4'h2: CondExE = c;
            4'h3: CondExE = ~c;
            4'h4: CondExE = n;
            4'h5: CondExE = ~n;
            4'h6: CondExE = v;
            4'h7: CondExE = ~v;
            4'h8: CondExE = c & ~z;
            4'h9: CondExE = ~c | z;
            4'hA: CondExE = n == v;
            4'hB: CondExE = n != v;
            4'hC: CondExE = ~z & (n == v);
            4'hD: CondExE = z | (n != v);
            4'hE: CondExE = 1'b1;
            default: CondExE = 1'b0;
        endcase
    end
    assign gate = CondExE & valid_q;
    assign upd = gate & ~StallE;
    assign ValidE = valid_q;
    assign Flags = flags_q;
    assign PCSrcE = pcsrc_f & gate;
    assign RegWriteE = regwrite_f & gate;
    assign MemWriteE = memwrite_f & gate;
    assign BranchTakenE = branch_f & gate;
    always_comb begin
        ctrl_d = FlushE ? '0 : StallE ? ctrl_q :
                 {PCSrcD, RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD, ALUControlD, FlagWriteD, CondD};
        valid_d = ~FlushE & (StallE ? valid_q : 1'b1);
        // The instruction leaving E updates flags even when a flush follows it.
        flags_d = upd ? (flags_q & ~fmask) | (ALUFlags & fmask) : flags_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q <= '0;
            valid_q <= 1'b0;
            flags_q <= 4'b0000;
        end else begin
            ctrl_q <= ctrl_d;
            valid_q <= valid_d;
            flags_q <= flags_d;
        end
    end
`ifdef COND_STATS_EN
    logic [CNT_W-1:0] exec_d, exec_q, squash_d, squash_q;
    always_comb begin
        exec_d = exec_q + CNT_W'(upd);
        squash_d = squash_q + CNT_W'(valid_q & ~StallE & ~CondExE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            exec_q <= '0;
            squash_q <= '0;
        end else begin
            exec_q <= exec_d;
            squash_q <= squash_d;
        end
    end
    assign ExecCnt = exec_q;
    assign SquashCnt = squash_q;
`endif
endmodule
